int_ctrl: RTL and testbench

Interrupt controller for the single-cycle CPU. It produces the interrupt side of the PC-source selection: the vector address and a one-cycle take request that the PC path uses to select `PC_SRC_INTERRUPT`. It latches and prioritises edge-triggered IRQ lines, applies a software mask, and saves the return PC (EPC). It then holds off further interrupts until the handler executes ERET.

---
 rtl/int_ctrl_pkg.sv | 20 ++
 rtl/int_ctrl_prio_enc.sv | 21 ++
 rtl/int_ctrl.sv | 93 +++++++++
 tb/tb_int_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default vector
// base and the vector-address helper.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        INT_ST_IDLE    = 2'b00,
        INT_ST_TAKE    = 2'b01,
        INT_ST_SERVICE = 2'b10
    } int_state_e;

    localparam logic [31:0] INT_VEC_BASE_DEFAULT = 32'h0000_0100;
    localparam int          INT_CAUSE_W          = 3;

    function automatic logic [31:0] int_vec_addr(input logic [31:0] base,
                                                 input int stride,
                                                 input logic [INT_CAUSE_W-1:0] idx);
        return base + 32'(idx) * 32'(stride);
    endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N_IRQ = 4
) (
    input  logic [N_IRQ-1:0]       req,
    output logic                   found,
    output logic [INT_CAUSE_W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan downward so the lowest active index is the last one written.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = INT_CAUSE_W'(i);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched, masked, fixed-priority IRQs with a single
// non-nesting service level, saved return PC and registered outputs.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] VEC_BASE   = INT_VEC_BASE_DEFAULT,
    parameter int          VEC_STRIDE = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_IRQ-1:0]       IRQ,
    input  logic                   MASK_WE,
    input  logic [N_IRQ-1:0]       MASK_IN,
    input  logic                   ERET,
    input  logic [31:0]            RET_PC,
    output logic                   INT_TAKE,
    output logic [31:0]            INTERRUPT,
    output logic [31:0]            EPC,
    output logic [INT_CAUSE_W-1:0] CAUSE,
    output logic                   IN_SERVICE,
    output logic [N_IRQ-1:0]       PENDING
);

    int_state_e             state, state_nxt;
    logic [N_IRQ-1:0]       irq_prev, mask, irq_edge, req, clr;
    logic                   found;
    logic [INT_CAUSE_W-1:0] win;
    logic                   take_nxt, service_nxt;

    assign irq_edge = IRQ & ~irq_prev;
    assign req      = PENDING & mask;

    int_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
        .req  (req),
        .found(found),
        .idx  (win)
    );

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            clr[i] = (state == INT_ST_TAKE) && (CAUSE == INT_CAUSE_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= INT_ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INT_ST_IDLE:    if (found) state_nxt = INT_ST_TAKE;
            INT_ST_TAKE:    state_nxt = INT_ST_SERVICE;
            INT_ST_SERVICE: if (ERET) state_nxt = INT_ST_IDLE;
            default:        state_nxt = INT_ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        take_nxt    = (state_nxt == INT_ST_TAKE);
        service_nxt = (state_nxt == INT_ST_SERVICE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_prev   <= '0;
            PENDING    <= '0;
            mask       <= '0;
            INT_TAKE   <= 1'b0;
            IN_SERVICE <= 1'b0;
            CAUSE      <= '0;
            INTERRUPT  <= VEC_BASE;
            EPC        <= '0;
        end else begin
            irq_prev   <= IRQ;
            // A new edge on the line being taken re-arms it: set wins over clear.
            PENDING    <= (PENDING & ~clr) | irq_edge;
            INT_TAKE   <= take_nxt;
            IN_SERVICE <= service_nxt;
            if (MASK_WE) mask <= MASK_IN;
            if (state == INT_ST_IDLE && found) begin
                CAUSE     <= win;
                INTERRUPT <= int_vec_addr(VEC_BASE, VEC_STRIDE, win);
            end
            if (state == INT_ST_TAKE) EPC <= RET_PC;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: directed IRQ sequences push expected takes,
// a monitor pops and checks them whenever INT_TAKE is seen.
module tb_int_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  IRQ;
    logic        MASK_WE;
    logic [3:0]  MASK_IN;
    logic        ERET;
    logic [31:0] RET_PC;
    logic        INT_TAKE;
    logic [31:0] INTERRUPT;
    logic [31:0] EPC;
    logic [2:0]  CAUSE;
    logic        IN_SERVICE;
    logic [3:0]  PENDING;

    typedef struct {
        logic [2:0]  cause;
        logic [31:0] vec;
        logic [31:0] epc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        chk_epc = 1'b0;
    logic [31:0] epc_exp;

    int_ctrl #(.N_IRQ(4), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IRQ       (IRQ),
        .MASK_WE   (MASK_WE),
        .MASK_IN   (MASK_IN),
        .ERET      (ERET),
        .RET_PC    (RET_PC),
        .INT_TAKE  (INT_TAKE),
        .INTERRUPT (INTERRUPT),
        .EPC       (EPC),
        .CAUSE     (CAUSE),
        .IN_SERVICE(IN_SERVICE),
        .PENDING   (PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [2:0] c, input logic [31:0] v, input logic [31:0] e);
        exp_t x;
        x.cause = c;
        x.vec   = v;
        x.epc   = e;
        sb.push_back(x);
    endtask

    // Monitor: every INT_TAKE cycle must match the oldest expected take, and
    // the following cycle must show the saved EPC with IN_SERVICE raised.
    initial begin
        exp_t x;
        forever begin
            @(negedge CLK);
            if (chk_epc) begin
                check("epc_after_take", EPC, epc_exp);
                check("in_service_after_take", {31'b0, IN_SERVICE}, 32'd1);
                chk_epc = 1'b0;
            end
            if (INT_TAKE === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_take: got cause %0d vec 0x%0h, expected no take", CAUSE, INTERRUPT);
                end else begin
                    x = sb.pop_front();
                    check("take_cause", {29'b0, CAUSE}, {29'b0, x.cause});
                    check("take_vector", INTERRUPT, x.vec);
                    epc_exp = x.epc;
                    chk_epc = 1'b1;
                end
            end
        end
    end

    initial begin
        RST = 1'b1; IRQ = '0; MASK_WE = 1'b0; MASK_IN = '0; ERET = 1'b0; RET_PC = '0;
        tick(2);
        check("rst_int_take", {31'b0, INT_TAKE}, 32'd0);
        check("rst_interrupt", INTERRUPT, 32'h100);
        check("rst_epc", EPC, 32'h0);
        check("rst_cause", {29'b0, CAUSE}, 32'd0);
        check("rst_in_service", {31'b0, IN_SERVICE}, 32'd0);
        check("rst_pending", {28'b0, PENDING}, 32'd0);
        RST = 1'b0;
        tick();

        // Masked IRQ2 stays pending, fires once the mask opens.
        RET_PC = 32'h200;
        IRQ = 4'b0100; tick(); IRQ = '0; tick();
        check("masked_pending", {28'b0, PENDING}, 32'h4);
        tick(3);
        check("masked_no_take", {31'b0, INT_TAKE}, 32'd0);
        push(3'd2, 32'h120, 32'h200);
        MASK_WE = 1'b1; MASK_IN = 4'b1111; tick(); MASK_WE = 1'b0;
        check("mask_delay_no_take", {31'b0, INT_TAKE}, 32'd0);
        tick(3);
        check("irq2_pending_cleared", {28'b0, PENDING}, 32'd0);
        ERET = 1'b1; tick(); ERET = 1'b0;
        check("eret_clears_service", {31'b0, IN_SERVICE}, 32'd0);
        tick(2);

        // IRQ1 and IRQ3 together: IRQ1 first, IRQ3 two cycles after ERET.
        RET_PC = 32'h40;
        push(3'd1, 32'h110, 32'h40);
        push(3'd3, 32'h130, 32'h80);
        IRQ = 4'b1010; tick(); IRQ = '0;
        check("pair_pending", {28'b0, PENDING}, 32'hA);
        tick();
        check("pair_take_latency", {31'b0, INT_TAKE}, 32'd1);
        tick();
        check("pair_epc", EPC, 32'h40);
        check("pair_irq3_left", {28'b0, PENDING}, 32'h8);
        RET_PC = 32'h80;
        ERET = 1'b1; tick(); ERET = 1'b0;
        check("pair_eret_no_take", {31'b0, INT_TAKE}, 32'd0);
        tick();
        check("pair_irq3_take", {31'b0, INT_TAKE}, 32'd1);
        check("pair_irq3_vec", INTERRUPT, 32'h130);
        tick();
        ERET = 1'b1; tick(); ERET = 1'b0;
        tick();

        // IRQ0 held high for 10 cycles: one take only, then a re-rise retakes.
        push(3'd0, 32'h100, 32'h80);
        IRQ = 4'b0001;
        tick(3);
        ERET = 1'b1; tick(); ERET = 1'b0;
        tick(6);
        check("hold_no_repend", {28'b0, PENDING}, 32'd0);
        IRQ = '0; tick();
        push(3'd0, 32'h100, 32'h80);
        IRQ = 4'b0001; tick(); IRQ = '0;
        tick(2);

        // Re-pulse IRQ0 while servicing IRQ0: held pending until ERET.
        check("svc_cause0", {29'b0, CAUSE}, 32'd0);
        IRQ = 4'b0001; tick(); IRQ = '0; tick();
        check("svc_repend", {28'b0, PENDING}, 32'h1);
        tick(3);
        check("svc_still_service", {31'b0, IN_SERVICE}, 32'd1);
        push(3'd0, 32'h100, 32'h80);
        ERET = 1'b1; tick(); ERET = 1'b0;
        tick(2);

        // Reset during SERVICE with another request pending.
        IRQ = 4'b0010; tick(); IRQ = '0;
        RST = 1'b1; tick(); RST = 1'b0;
        check("midrst_in_service", {31'b0, IN_SERVICE}, 32'd0);
        check("midrst_epc", EPC, 32'h0);
        check("midrst_pending", {28'b0, PENDING}, 32'd0);
        check("midrst_interrupt", INTERRUPT, 32'h100);
        check("midrst_cause", {29'b0, CAUSE}, 32'd0);

        // ERET outside SERVICE is ignored; lost requests never fire.
        ERET = 1'b1; tick(); ERET = 1'b0;
        check("idle_eret_service", {31'b0, IN_SERVICE}, 32'd0);
        check("idle_eret_take", {31'b0, INT_TAKE}, 32'd0);
        MASK_WE = 1'b1; MASK_IN = 4'b1111; tick(); MASK_WE = 1'b0;
        tick(4);
        check("idle_eret_pending", {28'b0, PENDING}, 32'd0);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
